// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller: decodes ROM/RAM/I/O/unmapped space, inserts per-region read wait
// states behind a registered ready/data handshake, and posts writes as one-cycle strobes.
module cpu_bus_ctrl #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 2,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd_req,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_wr_data,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_ready,
    output logic        prot_err,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_q,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_wr_data,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wr_data,
    output logic        io_wr_en,
    output logic        io_rd_en,
    input  logic [7:0]  io_rd_data
);

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
    typedef enum logic [1:0] {RgnRam, RgnIo, RgnRom, RgnNone} region_e;

    function automatic region_e decode(input logic [15:0] a);
        if (!a[15])                 return RgnRam;
        else if (a[15:8] == 8'h90)  return RgnIo;
        else if (a[15:13] == 3'b111) return RgnRom;
        else                        return RgnNone;
    endfunction

    function automatic logic [CntW-1:0] wait_for(input region_e r);
        case (r)
            RgnRam:  return CntW'(RAM_WAIT);
            RgnIo:   return CntW'(IO_WAIT);
            RgnRom:  return CntW'(ROM_WAIT);
            default: return '0;
        endcase
    endfunction

    state_e          state_q, state_d;
    region_e         region_q, region_d, req_region;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [12:0]     rom_addr_q, rom_addr_d;
    logic [14:0]     ram_addr_q, ram_addr_d;
    logic [7:0]      io_addr_q, io_addr_d;
    logic [7:0]      ram_wdata_q, ram_wdata_d;
    logic [7:0]      io_wdata_q, io_wdata_d;
    logic            ram_we_q, ram_we_d;
    logic            io_wr_en_q, io_wr_en_d;
    logic            io_rd_en_q, io_rd_en_d;

    assign req_region = decode(cpu_addr);

    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        ready_d     = ready_q;
        err_d       = err_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        io_addr_d   = io_addr_q;
        ram_wdata_d = ram_wdata_q;
        io_wdata_d  = io_wdata_q;
        ram_we_d    = 1'b0;
        io_wr_en_d  = 1'b0;
        io_rd_en_d  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (cpu_wr_en || cpu_rd_req) begin
                    rom_addr_d = cpu_addr[12:0];
                    ram_addr_d = cpu_addr[14:0];
                    io_addr_d  = cpu_addr[7:0];
                end
                // A write wins over a simultaneous read; the read is dropped and flagged.
                if (cpu_wr_en) begin
                    ram_wdata_d = cpu_wr_data;
                    io_wdata_d  = cpu_wr_data;
                    ram_we_d    = (req_region == RgnRam);
                    io_wr_en_d  = (req_region == RgnIo);
                    if (cpu_rd_req) err_d = 1'b1;
                end else if (cpu_rd_req) begin
                    region_d   = req_region;
                    cnt_d      = wait_for(req_region);
                    ready_d    = 1'b0;
                    io_rd_en_d = (req_region == RgnIo);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cpu_rd_req || cpu_wr_en) err_d = 1'b1;
                if (cnt_q == '0) begin
                    case (region_q)
                        RgnRam:  rd_data_d = ram_q;
                        RgnIo:   rd_data_d = io_rd_data;
                        RgnRom:  rd_data_d = rom_q;
                        default: rd_data_d = OPEN_BUS;
                    endcase
                    ready_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            region_q    <= RgnNone;
            cnt_q       <= '0;
            rd_data_q   <= 8'h00;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            io_addr_q   <= '0;
            ram_wdata_q <= '0;
            io_wdata_q  <= '0;
            ram_we_q    <= 1'b0;
            io_wr_en_q  <= 1'b0;
            io_rd_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            io_addr_q   <= io_addr_d;
            ram_wdata_q <= ram_wdata_d;
            io_wdata_q  <= io_wdata_d;
            ram_we_q    <= ram_we_d;
            io_wr_en_q  <= io_wr_en_d;
            io_rd_en_q  <= io_rd_en_d;
        end
    end

    assign cpu_rd_data = rd_data_q;
    assign cpu_ready   = ready_q;
    assign prot_err    = err_q;
    assign rom_addr    = rom_addr_q;
    assign ram_addr    = ram_addr_q;
    assign io_addr     = io_addr_q;
    assign ram_wr_data = ram_wdata_q;
    assign io_wr_data  = io_wdata_q;
    assign ram_we      = ram_we_q;
    assign io_wr_en    = io_wr_en_q;
    assign io_rd_en    = io_rd_en_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench for cpu_bus_ctrl: stimulus queues expected read/write responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cpu_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd_req = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [7:0]  cpu_wr_data = '0;
    logic [7:0]  cpu_rd_data;
    logic        cpu_ready;
    logic        prot_err;
    logic [12:0] rom_addr;
    logic [7:0]  rom_q = 8'h00;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wr_data;
    logic        ram_we;
    logic [7:0]  ram_q = 8'h00;
    logic [7:0]  io_addr;
    logic [7:0]  io_wr_data;
    logic        io_wr_en;
    logic        io_rd_en;
    logic [7:0]  io_rd_data = 8'hEE;

    cpu_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_rd_req (cpu_rd_req),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_ready  (cpu_ready),
        .prot_err   (prot_err),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .ram_addr   (ram_addr),
        .ram_wr_data(ram_wr_data),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .io_addr    (io_addr),
        .io_wr_data (io_wr_data),
        .io_wr_en   (io_wr_en),
        .io_rd_en   (io_rd_en),
        .io_rd_data (io_rd_data)
    );

    always #5 clk = ~clk;

    // Memory models: synchronous ROM/RAM, I/O data valid only two cycles after io_rd_en.
    logic [7:0] ram_mem [0:32767];
    logic       io_p1 = 1'b0;

    always @(posedge clk) begin
        rom_q <= (rom_addr == 13'h0005) ? 8'h3C : (rom_addr[7:0] ^ 8'h5A);
        if (ram_we) ram_mem[ram_addr] <= ram_wr_data;
        ram_q      <= ram_mem[ram_addr];
        io_p1      <= io_rd_en;
        io_rd_data <= io_p1 ? ((io_addr == 8'h10) ? 8'h77 : io_addr) : 8'hEE;
    end

    typedef struct {
        logic [7:0] data;
        int         low;
    } rd_t;
    typedef struct {
        logic        is_io;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  low_cnt = 0;
    int  io_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on read completion (ready rising) and on every write strobe.
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (io_rd_en) io_cnt++;
        if (reset) begin
            low_cnt = 0;
        end else if (!cpu_ready) begin
            low_cnt++;
        end else if (low_cnt != 0) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_unexpected: got data %0h expected no read", cpu_rd_data);
            end else begin
                r = rd_q.pop_front();
                check("rd_data", cpu_rd_data, r.data);
                check("rd_ready_low_cycles", low_cnt, r.low);
            end
            low_cnt = 0;
        end
        if (ram_we || io_wr_en) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL wr_unexpected: got ram_we=%0b io_wr_en=%0b expected none",
                         ram_we, io_wr_en);
            end else begin
                w = wr_q.pop_front();
                check("wr_strobes", {ram_we, io_wr_en}, w.is_io ? 2'b01 : 2'b10);
                check("wr_addr", w.is_io ? {7'h0, io_addr} : ram_addr, w.addr);
                check("wr_data", w.is_io ? io_wr_data : ram_wr_data, w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses a read in cycle 0; returns in cycle 1.
    task automatic read_issue(input logic [15:0] a, input logic [7:0] exp, input int low);
        rd_t r;
        r.data = exp;
        r.low  = low;
        rd_q.push_back(r);
        cpu_addr   = a;
        cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
    endtask

    task automatic read_wait();
        int n = 0;
        while (!cpu_ready && n < 20) begin
            tick();
            n++;
        end
        check("read_completes", cpu_ready, 1'b1);
    endtask

    // kind: 0 dropped, 1 RAM, 2 I/O. Returns in cycle 1.
    task automatic write_op(input logic [15:0] a, input logic [7:0] d, input int kind);
        wr_t w;
        if (kind != 0) begin
            w.is_io = (kind == 2);
            w.addr  = (kind == 2) ? {7'h0, a[7:0]} : a[14:0];
            w.data  = d;
            wr_q.push_back(w);
        end
        cpu_addr    = a;
        cpu_wr_data = d;
        cpu_wr_en   = 1'b1;
        tick();
        cpu_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int io_base;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_rd_data", cpu_rd_data, 8'h00);
        check("rst_prot_err", prot_err, 1'b0);
        check("rst_strobes", {ram_we, io_wr_en, io_rd_en}, 3'b000);
        check("rst_addrs", {rom_addr, ram_addr, io_addr}, 36'h0);
        check("rst_wdata", {ram_wr_data, io_wr_data}, 16'h0);

        // ROM read, W=1
        read_issue(16'hE005, 8'h3C, 2);
        check("rom_addr_c1", rom_addr, 13'h0005);
        check("rom_ready_c1", cpu_ready, 1'b0);
        tick();
        check("rom_ready_c2", cpu_ready, 1'b0);
        read_wait();
        check("rom_data_c3", cpu_rd_data, 8'h3C);

        // RAM write then read
        write_op(16'h1234, 8'hA5, 1);
        check("ram_we_c1", ram_we, 1'b1);
        check("ram_addr_c1", ram_addr, 15'h1234);
        check("ram_wdata_c1", ram_wr_data, 8'hA5);
        tick();
        check("ram_we_c2", ram_we, 1'b0);
        read_issue(16'h1234, 8'hA5, 2);
        read_wait();

        // I/O read, W=2
        io_base = io_cnt;
        read_issue(16'h9010, 8'h77, 3);
        check("io_addr_c1", io_addr, 8'h10);
        check("io_rd_en_c1", io_rd_en, 1'b1);
        read_wait();
        check("io_rd_en_pulses", io_cnt - io_base, 1);

        // Unmapped read, dropped ROM write, I/O write, back-to-back RAM writes + read in cycle 1
        read_issue(16'hA000, 8'hFF, 1);
        read_wait();
        write_op(16'hF000, 8'h99, 0);
        write_op(16'h9020, 8'h42, 2);
        write_op(16'h0010, 8'h11, 1);
        write_op(16'h0011, 8'h22, 1);
        read_issue(16'h0011, 8'h22, 2);
        read_wait();
        read_issue(16'h0010, 8'h11, 2);
        read_wait();
        read_issue(16'hFFF0, 8'hAA, 2);
        read_wait();
        check("no_err_yet", prot_err, 1'b0);

        // rd_req during WAIT: ignored, flagged; in-flight read unchanged
        read_issue(16'h1234, 8'hA5, 2);
        cpu_addr   = 16'hE005;
        cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        check("busy_err", prot_err, 1'b1);
        check("busy_addr_held", rom_addr, 13'h1234);
        read_wait();

        // rd_req + wr_en together: write done, read dropped
        wr_q.push_back('{is_io: 1'b0, addr: 15'h0100, data: 8'h5A});
        cpu_addr    = 16'h0100;
        cpu_wr_data = 8'h5A;
        cpu_wr_en   = 1'b1;
        cpu_rd_req  = 1'b1;
        tick();
        cpu_wr_en  = 1'b0;
        cpu_rd_req = 1'b0;
        check("rdwr_ready", cpu_ready, 1'b1);
        repeat (3) tick();
        check("rdwr_ready_later", cpu_ready, 1'b1);
        read_issue(16'h0100, 8'h5A, 2);
        read_wait();
        check("err_sticky", prot_err, 1'b1);

        // Reset in cycle 1 of a RAM read: aborted, no capture
        cpu_addr   = 16'h0100;
        cpu_rd_req = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", cpu_ready, 1'b1);
        check("abort_rd_data", cpu_rd_data, 8'h00);
        check("abort_err", prot_err, 1'b0);
        check("abort_ram_addr", ram_addr, 15'h0);
        repeat (5) tick();
        check("abort_no_capture", cpu_rd_data, 8'h00);

        repeat (2) tick();
        check("rd_queue_empty", rd_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

CPU-side memory bus controller that sits directly downstream of the cornet CPU. It decodes each CPU access into ROM, RAM, I/O (chroni register window) or unmapped space. For reads it inserts per-region wait states, captures read data and drives `cpu_ready`; writes are posted as single-cycle strobes. It replaces the ad-hoc read-ready logic at system level and exposes one uniform ready/data handshake to the CPU.

## Interface
Parameters:
- ROM_WAIT, 1, extra wait cycles for ROM reads (≥1; ROM is synchronous, 1-cycle latency)
- RAM_WAIT, 1, extra wait cycles for RAM reads (≥1)
- IO_WAIT, 2, extra wait cycles for I/O reads (≥1)
- OPEN_BUS, 8'hFF, data returned for unmapped reads

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  16  access address, valid with rd_req/wr_en
- cpu_rd_req  in  1  one-cycle read request pulse
- cpu_wr_en  in  1  one-cycle write request pulse
- cpu_wr_data  in  8  write data, valid with wr_en
- cpu_rd_data  out  8  registered read data
- cpu_ready  out  1  registered; low while a read is in flight
- prot_err  out  1  sticky: request seen while busy, or rd+wr together
- rom_addr  out  13  registered ROM address
- rom_q  in  8  ROM data
- ram_addr  out  15  registered RAM address
- ram_wr_data  out  8  registered RAM write data
- ram_we  out  1  one-cycle RAM write strobe
- ram_q  in  8  RAM read data
- io_addr  out  8  registered I/O register index
- io_wr_data  out  8  registered I/O write data
- io_wr_en  out  1  one-cycle I/O write strobe
- io_rd_en  out  1  one-cycle I/O read strobe
- io_rd_data  in  8  I/O read data

## Operation
- Map: RAM 0x0000–0x7FFF; I/O 0x9000–0x90FF; ROM 0xE000–0xFFFF; all other addresses unmapped. Region is decoded from the address sampled with the request and latched.
- States: IDLE, WAIT, DONE.
  - IDLE + rd_req: latch address and region; load the wait counter with the region's WAIT (unmapped = 0); go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, capture the region's data input (rom_q / ram_q / io_rd_data / OPEN_BUS) into cpu_rd_data and go to DONE.
  - DONE: cpu_ready=1; go to IDLE in the same cycle. DONE is equivalent to IDLE and accepts a new request.
- Writes (IDLE/DONE + wr_en): the RAM or I/O strobe is asserted for exactly one cycle, with latched address and data. ROM or unmapped writes are dropped silently. cpu_ready is unaffected.
- Address outputs hold their last latched value between accesses. rom_addr = addr[12:0], ram_addr = addr[14:0], io_addr = addr[7:0].
- rd_req and wr_en in the same cycle: the write is performed, the read is dropped, and prot_err is set.
- Any rd_req or wr_en while in WAIT: ignored, and prot_err is set.
- Reset, including mid-read: state IDLE, cpu_ready=1, cpu_rd_data=8'h00, prot_err=0, all strobes 0, all address and write-data outputs 0. An aborted read never captures data.

## Timing
- Cycle 0 is the cycle in which the request is high, sampled at edge 1.
- Read with wait W:
  - Address outputs are valid from cycle 1.
  - io_rd_en is high in cycle 1 only.
  - cpu_ready is low in cycles 1..W+1.
  - Data is captured at edge W+2; cpu_ready=1 and cpu_rd_data are valid in cycle W+2.
  - Unmapped (W=0): ready low in cycle 1 only, data valid in cycle 2.
- Back-to-back: a new request is accepted in cycle W+2. Read throughput is 1 per W+2 cycles.
- Write: strobe, address and data are valid in cycle 1 only. A write every cycle is sustained. A read in cycle 1 after a write is legal.
- cpu_rd_data holds its value until the next read capture.

## Test plan
- Reset, then ROM read at 0xE005 with rom_q model returning 8'h3C -> rom_addr=13'h0005 from cycle 1, cpu_ready low cycles 1–2, cpu_rd_data=8'h3C with ready=1 in cycle 3.
- RAM write 0x1234←8'hA5, then read 0x1234 -> ram_we high in cycle 1 only with ram_addr=15'h1234 and ram_wr_data=8'hA5; the read returns 8'hA5 in cycle 3 of the read.
- I/O read 0x9010 with IO_WAIT=2 and the model driving 8'h77 two cycles after io_rd_en -> io_addr=8'h10, io_rd_en is a single pulse, cpu_ready low 3 cycles, data 8'h77.
- Unmapped read 0xA000 -> cpu_ready low 1 cycle, data 8'hFF. Write to 0xF000 -> no strobes.
- rd_req during WAIT, and rd_req+wr_en together -> prot_err=1 and stays set; the in-flight read completes unchanged; the write is performed.
- reset asserted in cycle 1 of a RAM read -> next cycle cpu_ready=1, cpu_rd_data=8'h00, prot_err=0; no later capture occurs.
